// File: rtl/fetch_sequencer.sv
// Fetch program counter sequencer: boot, sequential advance, stall/wait hold,
// and redirect with a multi-cycle pipeline flush.
module fetch_sequencer #(
    parameter int unsigned    DATA_WIDTH   = 32,
    parameter logic [31:0]    RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned    FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  imem_ready,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_valid,
    output logic                  flush,
    output logic                  misaligned,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        StBoot    = 2'd0,
        StFetch   = 2'd1,
        StWaitMem = 2'd2,
        StFlush   = 2'd3
    } state_e;

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [2:0]            r_flush_cnt;
    logic                  r_misaligned;

    logic                  w_fetching;
    logic [DATA_WIDTH-1:0] w_target_aligned;
    logic [DATA_WIDTH-1:0] w_pc_inc;

    assign w_fetching       = (r_state == StFetch) || (r_state == StWaitMem);
    assign w_target_aligned = {redirect_target[DATA_WIDTH-1:2], 2'b00};
    assign w_pc_inc         = r_pc + DATA_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StBoot;
            r_pc         <= RESET_VECTOR[DATA_WIDTH-1:0];
            r_flush_cnt  <= 3'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                StBoot: begin
                    r_state <= StFetch;
                end
                StFetch, StWaitMem: begin
                    if (redirect) begin
                        r_pc         <= w_target_aligned;
                        r_flush_cnt  <= 3'(FLUSH_CYCLES);
                        r_misaligned <= |redirect_target[1:0];
                        r_state      <= StFlush;
                    end else if (stall) begin
                        r_state <= r_state;
                    end else if (imem_ready) begin
                        r_pc    <= w_pc_inc;
                        r_state <= StFetch;
                    end else begin
                        r_state <= StWaitMem;
                    end
                end
                StFlush: begin
                    // A redirect here restarts the flush window for the new target.
                    if (redirect) begin
                        r_pc         <= w_target_aligned;
                        r_flush_cnt  <= 3'(FLUSH_CYCLES);
                        r_misaligned <= |redirect_target[1:0];
                    end else if (r_flush_cnt <= 3'd1) begin
                        r_flush_cnt <= 3'd0;
                        r_state     <= StFetch;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= StBoot;
                end
            endcase
        end
    end

    assign imem_req   = w_fetching;
    assign pc_valid   = w_fetching & imem_ready & ~stall & ~redirect;
    assign flush      = (r_state == StFlush);
    assign pc         = r_pc;
    assign misaligned = r_misaligned;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; inputs change and outputs
// are sampled around the falling clock edge.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misaligned;
    logic [1:0]  state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    fetch_sequencer #(
        .DATA_WIDTH  (32),
        .RESET_VECTOR(32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .misaligned     (misaligned),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);

        // Boot: one cycle with no request even though memory is ready
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("boot_state", 32'(state_dbg), 32'd0);
        chk("boot_req", 32'(imem_req), 32'd0);
        chk("boot_valid", 32'(pc_valid), 32'd0);
        @(negedge clk);
        chk("fetch_state", 32'(state_dbg), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);

        // Sequential stream 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_valid", 32'(pc_valid), 32'd1);
            @(negedge clk);
        end
        chk("seq_pc_end", pc, 32'h10);
        repeat (4) @(negedge clk);
        chk("pc_20", pc, 32'h20);

        // Stall with ready: hold, no accept
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", 32'(pc_valid), 32'd0);
            chk("stall_pc", pc, 32'h20);
            @(negedge clk);
        end
        chk("stall_state", 32'(state_dbg), 32'd1);

        // Wait states
        stall = 1'b0; imem_ready = 1'b0;
        #1;
        chk("wait_valid", 32'(pc_valid), 32'd0);
        @(negedge clk);
        chk("wait_state", 32'(state_dbg), 32'd2);
        chk("wait_pc", pc, 32'h20);
        chk("wait_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        chk("wait_state2", 32'(state_dbg), 32'd2);
        imem_ready = 1'b1;
        #1;
        chk("wait_accept", 32'(pc_valid), 32'd1);
        @(negedge clk);
        chk("wait_pc_next", pc, 32'h24);
        chk("wait_to_fetch", 32'(state_dbg), 32'd1);
        repeat (3) @(negedge clk);
        chk("pc_30", pc, 32'h30);

        // Redirect beats stall and discards the ready word
        redirect = 1'b1; redirect_target = 32'h100; stall = 1'b1;
        #1;
        chk("redir_valid", 32'(pc_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        chk("redir_pc", pc, 32'h100);
        chk("redir_state", 32'(state_dbg), 32'd3);
        chk("redir_flush1", 32'(flush), 32'd1);
        chk("redir_req", 32'(imem_req), 32'd0);
        chk("redir_valid_fl", 32'(pc_valid), 32'd0);
        chk("redir_mis", 32'(misaligned), 32'd0);
        @(negedge clk);
        chk("redir_flush2", 32'(flush), 32'd1);
        chk("redir_req2", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("redir_fetch", 32'(state_dbg), 32'd1);
        chk("redir_flush_off", 32'(flush), 32'd0);
        chk("redir_req_on", 32'(imem_req), 32'd1);
        chk("redir_pc_keep", pc, 32'h100);

        // Redirect, then a misaligned redirect during the flush window
        redirect = 1'b1; redirect_target = 32'h180;
        @(negedge clk);
        chk("rr_pc1", pc, 32'h180);
        redirect_target = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        chk("rr_pc2", pc, 32'h200);
        chk("rr_mis", 32'(misaligned), 32'd1);
        chk("rr_flush1", 32'(flush), 32'd1);
        @(negedge clk);
        chk("rr_mis_off", 32'(misaligned), 32'd0);
        chk("rr_flush2", 32'(flush), 32'd1);
        @(negedge clk);
        chk("rr_flush_off", 32'(flush), 32'd0);
        chk("rr_state", 32'(state_dbg), 32'd1);
        chk("rr_pc", pc, 32'h200);

        // Mid-run asynchronous reset at pc=0x40
        redirect = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        redirect = 1'b0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_pc", pc, 32'h40);
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_state", 32'(state_dbg), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("reboot_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        chk("reboot_req", 32'(imem_req), 32'd1);
        chk("reboot_pc", pc, 32'h0);

        // Wrap at the top of the address space
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        #1;
        chk("wrap_valid", 32'(pc_valid), 32'd1);
        @(negedge clk);
        chk("wrap_pc", pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
